// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, FSM state encodings and the
// byte-lane merge used when a write carries a partial strobe.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
      else         res[8*k +: 8] = old_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// NREG x 32-bit register storage with byte-strobe merge, a registered
// one-hot update pulse, and a combinational read mux.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [31:0]          wr_data,
  input  logic [3:0]           wr_strb,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [31:0]          rd_data,
  output logic [NREG*32-1:0]   reg_out,
  output logic [NREG-1:0]      wr_pulse
);

  logic [NREG-1:0][31:0] regs_q, regs_d;
  logic [NREG-1:0]       pulse_q, pulse_d;

  // Next register contents and update pulse for this cycle's commit.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = {NREG{1'b0}};
    if (wr_en) begin
      regs_d[wr_idx]  = strb_merge(regs_q[wr_idx], wr_data, wr_strb);
      pulse_d[wr_idx] = 1'b1;
    end else begin
      pulse_d = {NREG{1'b0}};
    end
  end

  // Storage and pulse flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q  <= {(NREG*32){1'b0}};
      pulse_q <= {NREG{1'b0}};
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  assign rd_data  = regs_q[rd_idx];
  assign reg_out  = regs_q;
  assign wr_pulse = pulse_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: independent write and read FSMs in front of a
// register bank. Address bits [1:0] are ignored; high bits must be zero.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [ADDR_W-1:0]    araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [NREG*32-1:0]   reg_out,
  output logic [NREG-1:0]      wr_pulse
);

  localparam int IDX_W = $clog2(NREG);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ((a >> (IDX_W + 2)) == {ADDR_W{1'b0}});
  endfunction

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d, rd_data_s;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic                rdy_en_q;
  logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s, bank_we_s;
  logic [ADDR_W-1:0]   cm_addr_s;
  logic [31:0]         cm_data_s;
  logic [3:0]          cm_strb_s;

  // Ready gating keeps all channels closed until the first edge after reset.
  assign awready = rdy_en_q & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_W));
  assign wready  = rdy_en_q & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_AW));
  assign arready = rdy_en_q & (r_state_q == R_IDLE);
  assign aw_hs_s = awvalid & awready;
  assign w_hs_s  = wvalid & wready;
  assign ar_hs_s = arvalid & arready;

  // Write FSM next state; commit fires on the second handshake of the pair.
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    commit_s  = 1'b0;
    cm_addr_s = awaddr_q;
    cm_data_s = wdata_q;
    cm_strb_s = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s  = 1'b1;
          cm_addr_s = awaddr;
          cm_data_s = wdata;
          cm_strb_s = wstrb;
        end else if (aw_hs_s) begin
          awaddr_d  = awaddr;
          w_state_d = W_HAVE_AW;
        end else if (w_hs_s) begin
          wdata_d   = wdata;
          wstrb_d   = wstrb;
          w_state_d = W_HAVE_W;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_HAVE_AW: begin
        if (w_hs_s) begin
          commit_s  = 1'b1;
          cm_data_s = wdata;
          cm_strb_s = wstrb;
        end else begin
          w_state_d = W_HAVE_AW;
        end
      end
      W_HAVE_W: begin
        if (aw_hs_s) begin
          commit_s  = 1'b1;
          cm_addr_s = awaddr;
        end else begin
          w_state_d = W_HAVE_W;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
    endcase
    if (commit_s) begin
      w_state_d = W_RESP;
      bvalid_d  = 1'b1;
      bresp_d   = addr_ok(cm_addr_s) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      bresp_d = bresp_q;
    end
  end

  assign bank_we_s = commit_s & addr_ok(cm_addr_s) & (|cm_strb_s);

  // Read FSM next state; data is captured from the bank on the handshake.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rdata_d   = addr_ok(araddr) ? rd_data_s : 32'h0000_0000;
          rresp_d   = addr_ok(araddr) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // Write and read FSM state, capture registers and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      awaddr_q  <= {ADDR_W{1'b0}};
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      bresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      r_state_q <= R_IDLE;
      rdata_q   <= 32'h0000_0000;
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;

  axi_lite_reg_bank #(.NREG(NREG), .IDX_W(IDX_W)) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bank_we_s),
    .wr_idx   (cm_addr_s[IDX_W+1:2]),
    .wr_data  (cm_data_s),
    .wr_strb  (cm_strb_s),
    .rd_idx   (araddr[IDX_W+1:2]),
    .rd_data  (rd_data_s),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse)
  );

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: expected responses queued on issue,
// checked on the response handshake; register state checked against a model.
module tb_axi_lite_reg_slave;

  localparam int NREG   = 16;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic [NREG*32-1:0] reg_out;
  logic [NREG-1:0]   wr_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] model [NREG];

  always #5 clk = ~clk;

  axi_lite_reg_slave #(.NREG(NREG), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [NREG*32-1:0] e;
    for (int i = 0; i < NREG; i++) e[32*i +: 32] = model[i];
    n_cmp++;
    assert (reg_out === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, reg_out, e);
    end
  endtask

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    logic [25:0] hi;
    hi = a[31:6];
    return (hi == 26'd0) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] pulse_of(input logic [31:0] a, input logic [3:0] s);
    logic [3:0] idx;
    idx = a[5:2];
    if (resp_of(a) == 2'b00 && s != 4'h0) return 32'd1 << idx;
    else return 32'd0;
  endfunction

  task automatic model_upd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [3:0] idx;
    idx = a[5:2];
    if (resp_of(a) == 2'b00) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  function automatic logic [33:0] rd_exp(input logic [31:0] a);
    logic [3:0] idx;
    idx = a[5:2];
    if (resp_of(a) == 2'b00) return {2'b00, model[idx]};
    else return {2'b10, 32'h0000_0000};
  endfunction

  // Same-cycle AW+W; returns at the negedge after the handshake edge.
  task automatic wr_same(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    chk("awready_idle", {31'd0, awready}, 32'd1);
    chk("wready_idle", {31'd0, wready}, 32'd1);
    bq.push_back(resp_of(a));
    model_upd(a, d, s);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic post_write(input logic [31:0] a, input logic [3:0] s);
    chk("bvalid_after_commit", {31'd0, bvalid}, 32'd1);
    chk("wr_pulse", {16'd0, wr_pulse}, pulse_of(a, s));
    chk_regs("reg_out_after_commit");
  endtask

  task automatic drain_b();
    logic [1:0] e;
    bit seen;
    seen = 1'b0;
    bready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bvalid === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        assert (bq.size() != 0) else begin
          n_bad++;
          $error("FAIL b_unexpected: observed bvalid with %0d queued, expected >0", bq.size());
        end
        e = (bq.size() != 0) ? bq.pop_front() : 2'bxx;
        chk("bresp", {30'd0, bresp}, {30'd0, e});
      end
      tick();
    end
    bready = 1'b0;
    chk("b_handshake", {31'd0, seen}, 32'd1);
    chk("bvalid_dropped", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic rd_issue(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
    chk("arready_idle", {31'd0, arready}, 32'd1);
    rq.push_back(rd_exp(a));
    tick();
    arvalid = 1'b0;
  endtask

  task automatic drain_r();
    logic [33:0] e;
    bit seen;
    seen = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rvalid === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        assert (rq.size() != 0) else begin
          n_bad++;
          $error("FAIL r_unexpected: observed rvalid with %0d queued, expected >0", rq.size());
        end
        e = (rq.size() != 0) ? rq.pop_front() : {34{1'bx}};
        chk("rdata", rdata, e[31:0]);
        chk("rresp", {30'd0, rresp}, {30'd0, e[33:32]});
      end
      tick();
    end
    rready = 1'b0;
    chk("r_handshake", {31'd0, seen}, 32'd1);
    chk("rvalid_dropped", {31'd0, rvalid}, 32'd0);
    chk("arready_back", {31'd0, arready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    awaddr = 32'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = 32'd0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    repeat (3) tick();

    // Reset state
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wr_pulse", {16'd0, wr_pulse}, 32'd0);
    chk_regs("rst_reg_out");
    reset = 1'b0;
    chk("awready_before_edge", {31'd0, awready}, 32'd0);
    tick();
    chk("awready_after_edge", {31'd0, awready}, 32'd1);
    chk("arready_after_edge", {31'd0, arready}, 32'd1);

    // Same-cycle write, response held one extra cycle
    wr_same(32'h08, 32'hDEAD_BEEF, 4'hF);
    post_write(32'h08, 4'hF);
    chk("reg2_deadbeef", reg_out[2*32 +: 32], 32'hDEAD_BEEF);
    chk("wr_pulse_reg2", {16'd0, wr_pulse}, 32'h0000_0004);
    tick();
    chk("wr_pulse_one_cycle", {16'd0, wr_pulse}, 32'd0);
    chk("bvalid_held", {31'd0, bvalid}, 32'd1);
    chk("awready_in_resp", {31'd0, awready}, 32'd0);
    chk("wready_in_resp", {31'd0, wready}, 32'd0);
    drain_b();

    // W first, AW three cycles later, byte 0 only
    wr_same(32'h0C, 32'h1122_3344, 4'hF);
    post_write(32'h0C, 4'hF);
    drain_b();
    wdata = 32'h0000_00AA; wstrb = 4'h1; wvalid = 1'b1;
    chk("wready_idle_wfirst", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    chk("wready_after_w", {31'd0, wready}, 32'd0);
    chk("awready_have_w", {31'd0, awready}, 32'd1);
    tick();
    chk("wready_still_low", {31'd0, wready}, 32'd0);
    tick();
    awaddr = 32'h0C; awvalid = 1'b1;
    bq.push_back(resp_of(32'h0C));
    model_upd(32'h0C, 32'h0000_00AA, 4'h1);
    tick();
    awvalid = 1'b0;
    post_write(32'h0C, 4'h1);
    chk("reg3_byte0", reg_out[3*32 +: 32], 32'h1122_33AA);
    drain_b();

    // AW first, then W with lanes 1 and 3
    wr_same(32'h14, 32'hCAFE_F00D, 4'hF);
    drain_b();
    awaddr = 32'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("awready_have_aw", {31'd0, awready}, 32'd0);
    chk("wready_have_aw", {31'd0, wready}, 32'd1);
    wdata = 32'hAABB_CCDD; wstrb = 4'hA; wvalid = 1'b1;
    bq.push_back(resp_of(32'h14));
    model_upd(32'h14, 32'hAABB_CCDD, 4'hA);
    tick();
    wvalid = 1'b0;
    post_write(32'h14, 4'hA);
    chk("reg5_lanes", reg_out[5*32 +: 32], 32'hAAFE_CC0D);
    drain_b();

    // Zero strobe and out-of-range writes
    wr_same(32'h08, 32'hFFFF_FFFF, 4'h0);
    post_write(32'h08, 4'h0);
    drain_b();
    wr_same(32'h100, 32'h5555_5555, 4'hF);
    post_write(32'h100, 4'hF);
    chk("oor_pulse", {16'd0, wr_pulse}, 32'd0);
    drain_b();

    // Read with rready held low for 4 cycles
    rd_issue(32'h08);
    for (int i = 0; i < 4; i++) begin
      chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
      chk("rdata_hold", rdata, 32'hDEAD_BEEF);
      chk("arready_busy", {31'd0, arready}, 32'd0);
      tick();
    end
    drain_r();

    // Read coinciding with a write commit to the same register
    awaddr = 32'h08; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h08; arvalid = 1'b1;
    rq.push_back(rd_exp(32'h08));
    bq.push_back(resp_of(32'h08));
    model_upd(32'h08, 32'h1234_5678, 4'hF);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("collide_old_value", rdata, 32'hDEAD_BEEF);
    chk("collide_reg2_new", reg_out[2*32 +: 32], 32'h1234_5678);
    drain_r();
    drain_b();
    rd_issue(32'h08);
    drain_r();

    // Ignored low address bits and out-of-range read
    rd_issue(32'h0E);
    drain_r();
    rd_issue(32'h40);
    drain_r();

    // Reset while a response is pending
    wr_same(32'h04, 32'h0BAD_F00D, 4'hF);
    chk("bvalid_pending", {31'd0, bvalid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("bvalid_async_drop", {31'd0, bvalid}, 32'd0);
    chk("awready_in_reset", {31'd0, awready}, 32'd0);
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    bq.delete();
    chk_regs("regs_cleared");
    tick();
    reset = 1'b0;
    tick();
    chk("awready_after_rerelease", {31'd0, awready}, 32'd1);
    wr_same(32'h04, 32'h600D_CAFE, 4'hF);
    post_write(32'h04, 4'hF);
    drain_b();
    chk_regs("final_regs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: NREG, 16, number of 32-bit registers (power of two, 2..64).
REQ-003 Parameter: ADDR_W, 32, AXI address width.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high.
REQ-006 Ports: awaddr in ADDR_W; awvalid in 1; awready out 1. Write address channel.
REQ-007 Ports: wdata in 32; wstrb in 4; wvalid in 1; wready out 1. Write data channel.
REQ-008 Ports: bresp out 2; bvalid out 1; bready in 1. Write response channel.
REQ-009 Ports: araddr in ADDR_W; arvalid in 1; arready out 1. Read address channel.
REQ-010 Ports: rdata out 32; rresp out 2; rvalid out 1; rready in 1. Read data channel.
REQ-011 Port: reg_out  out  NREG*32  all registers; register i in bits [32i+31:32i].
REQ-012 Port: wr_pulse  out  NREG  one-hot, one cycle, marks a register update.

Function
REQ-013 Decode: index = addr[log2(NREG)+1:2]; addr[1:0] ignored; in range iff addr[ADDR_W-1:log2(NREG)+2] == 0.
REQ-014 Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-015 awready = 1 in W_IDLE and W_HAVE_W; wready = 1 in W_IDLE and W_HAVE_AW; both 0 in W_RESP.
REQ-016 W_IDLE: AW+W handshake in the same cycle -> W_RESP; AW only -> W_HAVE_AW (capture address); W only -> W_HAVE_W (capture data and strobe).
REQ-017 W_HAVE_AW + W handshake -> W_RESP; W_HAVE_W + AW handshake -> W_RESP.
REQ-018 Commit happens on the cycle the second handshake completes. The new value appears on reg_out, and wr_pulse[index] = 1, in the following cycle.
REQ-019 Byte lane k updates only when wstrb[k] = 1. wstrb = 0 writes nothing, asserts no wr_pulse, and returns bresp 2'b00.
REQ-020 Out-of-range write: no register change, no wr_pulse, bresp = 2'b10 (SLVERR). In-range write: bresp = 2'b00.
REQ-021 W_RESP: bvalid = 1 with bresp held stable until bready; on bvalid & bready -> W_IDLE, and bvalid drops next cycle.
REQ-022 Read FSM states: R_IDLE (arready = 1, rvalid = 0) and R_DATA (arready = 0, rvalid = 1).
REQ-023 R_IDLE + arvalid -> R_DATA. rdata captures the register value as of the handshake cycle, so latency is 1 cycle.
REQ-024 Out-of-range read: rdata = 0, rresp = 2'b10. In range: rresp = 2'b00.
REQ-025 R_DATA: rdata and rresp held stable until rready; on rvalid & rready -> R_IDLE. Read throughput is at most one per 2 cycles.
REQ-026 Read and write FSMs are independent. If a read handshake coincides with a write commit to the same register, the read returns the pre-write value.
REQ-027 Master valid signals are sampled only under handshake rules; valid without ready has no side effect.

Reset
REQ-028 reset = 1 asynchronously forces: all registers 0; reg_out 0; wr_pulse 0; bvalid 0; bresp 2'b00; rvalid 0; rdata 0; rresp 2'b00; W_IDLE; R_IDLE.
REQ-029 awready, wready and arready SHALL be 0 while reset = 1, and 1 from the first clock edge after deassertion.
REQ-030 Reset mid-transaction discards partially captured AW/W and pending responses; no register update occurs.

Structure
REQ-031 Shared package axi_lite_pkg holds RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, and the write/read state encodings.
REQ-032 One sub-module, axi_lite_reg_bank, holds the NREG x 32 storage, byte-strobe merge, wr_pulse generation and the combinational read mux. The top holds both FSMs and the capture registers.

Verification
REQ-033 Same-cycle AW 0x08 + W 0xDEADBEEF, wstrb 4'hF -> bvalid next cycle, bresp 00; reg_out reg2 = 0xDEADBEEF; wr_pulse = 0x0004 for one cycle.
REQ-034 W first (0x000000AA, wstrb 4'h1), AW 0x0C three cycles later -> wready low after W handshake; reg3 = 0x000000AA; only byte 0 changes.
REQ-035 AW 0x100 (out of range), any W -> bresp 10; no reg_out change; wr_pulse stays 0.
REQ-036 Read 0x08 with rready held low 4 cycles -> rvalid stays 1 with rdata 0xDEADBEEF stable; arready 0 until the rready handshake.
REQ-037 Read 0x08 in the same cycle as a write committing 0x12345678 to 0x08 -> rdata = old value; the next read returns 0x12345678.
REQ-038 Reset asserted while in W_RESP with bready low -> bvalid drops immediately, all registers read 0, and a new write completes normally after release.
